// File: rtl/checksum_arbiter_if.sv
// rtl/checksum_arbiter_if.sv - requester-side and engine-side bus of the checksum arbiter
interface checksum_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    req_data_valid;
  logic [8*NUM_REQ-1:0]  req_data;
  logic [NUM_REQ-1:0]    req_end_of_frame;
  logic [16*NUM_REQ-1:0] req_expected;
  logic [NUM_REQ-1:0]    result_valid;
  logic                  result_correct;
  logic [15:0]           result_value;
  logic                  result_error;
  logic                  busy;
  logic                  cs_reset;
  logic                  cs_data_valid;
  logic [7:0]            cs_data;
  logic                  cs_end_of_frame;
  logic [15:0]           cs_expected;
  logic                  cs_done;
  logic                  cs_correct;
  logic [15:0]           cs_value;

  modport slave (
    input  req, req_data_valid, req_data, req_end_of_frame, req_expected,
    input  cs_done, cs_correct, cs_value,
    output grant, result_valid, result_correct, result_value, result_error, busy,
    output cs_reset, cs_data_valid, cs_data, cs_end_of_frame, cs_expected
  );

  modport master (
    output req, req_data_valid, req_data, req_end_of_frame, req_expected,
    output cs_done, cs_correct, cs_value,
    input  grant, result_valid, result_correct, result_value, result_error, busy,
    input  cs_reset, cs_data_valid, cs_data, cs_end_of_frame, cs_expected
  );
endinterface

// File: rtl/checksum_arbiter.sv
// rtl/checksum_arbiter.sv - round-robin sharing of one checksum engine between byte-stream requesters
// One frame per grant; a watchdog plus engine-reset pulse recovers hung or abandoned frames.
module checksum_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int FLUSH_CYCLES   = 2
) (
  input logic               clock,
  input logic               reset,
  checksum_arbiter_if.slave bus
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT_DONE,
    S_FLUSH,
    S_RESULT
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   result_valid_q, result_valid_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [WW-1:0]        wd_q, wd_d;
  logic [FW-1:0]        flush_cnt_q, flush_cnt_d;
  logic                 cs_data_valid_q, cs_data_valid_d;
  logic [7:0]           cs_data_q, cs_data_d;
  logic                 cs_end_of_frame_q, cs_end_of_frame_d;
  logic [15:0]          cs_expected_q, cs_expected_d;
  logic                 result_correct_q, result_correct_d;
  logic [15:0]          result_value_q, result_value_d;
  logic                 result_error_q, result_error_d;

  logic                 pick_found;
  logic [OW-1:0]        pick_idx;
  logic [7:0]           own_data;
  logic [15:0]          own_expected;
  logic                 own_valid;
  logic                 own_eof;
  logic                 own_req;

  assign own_data     = bus.req_data[{owner_q, 3'b000} +: 8];
  assign own_expected = bus.req_expected[{owner_q, 4'b0000} +: 16];
  assign own_valid    = bus.req_data_valid[owner_q];
  assign own_eof      = bus.req_end_of_frame[owner_q];
  assign own_req      = bus.req[owner_q];

  // First requesting index at or above rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && bus.req[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
        pick_found = 1'b1;
        pick_idx   = OW'((int'(rr_ptr_q) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    owner_d           = owner_q;
    rr_ptr_d          = rr_ptr_q;
    wd_d              = wd_q;
    flush_cnt_d       = flush_cnt_q;
    cs_data_valid_d   = 1'b0;
    cs_data_d         = cs_data_q;
    cs_end_of_frame_d = 1'b0;
    cs_expected_d     = cs_expected_q;
    result_valid_d    = '0;
    result_correct_d  = result_correct_q;
    result_value_d    = result_value_q;
    result_error_d    = result_error_q;

    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          state_d           = S_STREAM;
        end
      end
      S_STREAM: begin
        cs_data_valid_d   = own_valid;
        cs_data_d         = own_data;
        cs_end_of_frame_d = own_eof;
        cs_expected_d     = own_expected;
        if (own_eof) begin
          wd_d    = '0;
          state_d = S_WAIT_DONE;
        end else if (!own_req) begin
          flush_cnt_d = '0;
          state_d     = S_FLUSH;
        end
      end
      S_WAIT_DONE: begin
        wd_d = wd_q + WW'(1);
        // A done arriving on the timeout cycle still counts as a good result.
        if (bus.cs_done) begin
          result_correct_d = bus.cs_correct;
          result_value_d   = bus.cs_value;
          result_error_d   = 1'b0;
          result_valid_d   = grant_q;
          grant_d          = '0;
          state_d          = S_RESULT;
        end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
          flush_cnt_d = '0;
          state_d     = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == FW'(FLUSH_CYCLES - 1)) begin
          result_correct_d = 1'b0;
          result_value_d   = '0;
          result_error_d   = 1'b1;
          result_valid_d   = grant_q;
          grant_d          = '0;
          state_d          = S_RESULT;
        end else begin
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
      end
      S_RESULT: begin
        rr_ptr_d = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= S_IDLE;
      grant_q           <= '0;
      owner_q           <= '0;
      rr_ptr_q          <= '0;
      wd_q              <= '0;
      flush_cnt_q       <= '0;
      cs_data_valid_q   <= 1'b0;
      cs_data_q         <= '0;
      cs_end_of_frame_q <= 1'b0;
      cs_expected_q     <= '0;
      result_valid_q    <= '0;
      result_correct_q  <= 1'b0;
      result_value_q    <= '0;
      result_error_q    <= 1'b0;
    end else begin
      state_q           <= state_d;
      grant_q           <= grant_d;
      owner_q           <= owner_d;
      rr_ptr_q          <= rr_ptr_d;
      wd_q              <= wd_d;
      flush_cnt_q       <= flush_cnt_d;
      cs_data_valid_q   <= cs_data_valid_d;
      cs_data_q         <= cs_data_d;
      cs_end_of_frame_q <= cs_end_of_frame_d;
      cs_expected_q     <= cs_expected_d;
      result_valid_q    <= result_valid_d;
      result_correct_q  <= result_correct_d;
      result_value_q    <= result_value_d;
      result_error_q    <= result_error_d;
    end
  end

  assign bus.grant           = grant_q;
  assign bus.result_valid    = result_valid_q;
  assign bus.result_correct  = result_correct_q;
  assign bus.result_value    = result_value_q;
  assign bus.result_error    = result_error_q;
  assign bus.busy            = (state_q != S_IDLE);
  assign bus.cs_reset        = reset | (state_q == S_FLUSH);
  assign bus.cs_data_valid   = cs_data_valid_q;
  assign bus.cs_data         = cs_data_q;
  assign bus.cs_end_of_frame = cs_end_of_frame_q;
  assign bus.cs_expected     = cs_expected_q;
endmodule
